// File: rtl/dti_upsize.sv
// Width upsizer: packs RATIO narrow {eot,payload} words LSB-first into one
// registered wide word {eot, cnt, word[RATIO-1..0]}; eot flushes a partial group.
module dti_upsize #(
  parameter  int DIN   = 16,
  parameter  int RATIO = 4,
  localparam int CNTW  = $clog2(RATIO + 1),
  localparam int OW    = 1 + CNTW + RATIO * DIN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DIN:0]  din_data_i,
  input  logic          din_valid_i,
  output logic          din_ready_o,
  output logic [OW-1:0] dout_data_o,
  output logic          dout_valid_o,
  input  logic          dout_ready_i
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RATIO*DIN-1:0] slots_q, slots_d, slotsWr;
  logic [OW-1:0]        outData_q, outData_d;
  logic                 outValid_q, outValid_d;

  logic                 accept;
  logic                 inEot;
  logic                 closeGrp;
  logic [CNTW-1:0]      grpCnt;

  assign din_ready_o  = ~outValid_q | dout_ready_i;
  assign accept       = din_valid_i & din_ready_o;
  assign inEot        = din_data_i[DIN];
  assign closeGrp     = accept & (inEot | (cnt_q == CW'(RATIO - 1)));
  assign grpCnt       = CNTW'(cnt_q) + CNTW'(1);
  assign dout_data_o  = outData_q;
  assign dout_valid_o = outValid_q;

  // Slots above cnt_q are always zero because a closing group clears them all.
  always_comb begin
    slotsWr = slots_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) slotsWr[i*DIN +: DIN] = din_data_i[DIN-1:0];
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    slots_d    = slots_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    if (outValid_q && dout_ready_i) outValid_d = 1'b0;
    if (closeGrp) begin
      outData_d  = {inEot, grpCnt, slotsWr};
      outValid_d = 1'b1;
      cnt_d      = '0;
      slots_d    = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + CW'(1);
      slots_d = slotsWr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      slots_q    <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slots_q    <= slots_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

endmodule
